// File: rtl/decode.sv
// Decode / operand-fetch stage. Splits an instruction into exec fields, reads
// operands from the integer and float register files held here, forms
// immediates and addresses, and presents them registered with a done pulse.
// The writeback port from exec updates the register files, and a write in the
// same cycle as a read of the same file/index is returned to the reader.
module decode (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        done,
    output logic [5:0]  exec_command,
    output logic [5:0]  alu_command,
    output logic [15:0] offset,
    output logic [4:0]  sh,
    output logic [4:0]  rs_no,
    output logic [4:0]  rt_no,
    output logic [4:0]  rd_out,
    output logic        fmode1,
    output logic        fmode2,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [31:0] addr,
    output logic [31:0] pc_out,
    input  logic [2:0]  wb_sel,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_FPU   = 6'b010001,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_LF    = 6'b110001,
        OP_BC    = 6'b110010,
        OP_SF    = 6'b111001,
        OP_EXT   = 6'b111111
    } opcode_t;

    logic [31:0] int_rf [32];
    logic [31:0] fp_rf  [32];

    logic [5:0]  op;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [31:0] imm_s;
    logic        wr_int;
    logic        wr_fp;
    logic [31:0] rs_int;
    logic [31:0] rs_fp;
    logic [31:0] rt_int;
    logic [31:0] rt_fp;
    logic        is_r;
    logic        d_fm1;
    logic        d_fm2;
    logic [5:0]  d_alu;
    logic [4:0]  d_rd;
    logic [31:0] d_rs;
    logic [31:0] d_rt;
    logic [31:0] d_addr;
    logic        unused_wb_sel;

    // wb_sel[2] belongs to exec and carries no meaning for the register files
    assign unused_wb_sel = wb_sel[2];

    // Register file update from the exec writeback port; int r0 stays zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                int_rf[i[4:0]] <= '0;
                fp_rf[i[4:0]]  <= '0;
            end
        end else if (wb_sel[1]) begin
            if (wb_sel[0]) begin
                fp_rf[wb_rd] <= wb_data;
            end else if (wb_rd != 5'd0) begin
                int_rf[wb_rd] <= wb_data;
            end
        end
    end

    // Operand reads with write-first bypass of the same-cycle writeback
    always_comb begin
        op     = instr[31:26];
        rs_idx = instr[25:21];
        rt_idx = instr[20:16];
        imm_s  = {{16{instr[15]}}, instr[15:0]};
        wr_int = wb_sel[1] & ~wb_sel[0] & (wb_rd != 5'd0);
        wr_fp  = wb_sel[1] & wb_sel[0];
        rs_int = (wr_int && wb_rd == rs_idx) ? wb_data : int_rf[rs_idx];
        rs_fp  = (wr_fp  && wb_rd == rs_idx) ? wb_data : fp_rf[rs_idx];
        rt_int = (wr_int && wb_rd == rt_idx) ? wb_data : int_rf[rt_idx];
        rt_fp  = (wr_fp  && wb_rd == rt_idx) ? wb_data : fp_rf[rt_idx];
    end

    // Field decode, operand selection and address formation
    always_comb begin
        is_r   = (op == OP_RTYPE) || (op == OP_FPU) || (op == OP_EXT);
        d_fm1  = (op == OP_FPU);
        d_fm2  = (op == OP_FPU) || (op == OP_SF);
        d_alu  = is_r ? instr[5:0] : '0;
        d_rs   = d_fm1 ? rs_fp : rs_int;
        d_rd   = '0;
        d_rt   = d_fm2 ? rt_fp : rt_int;
        d_addr = '0;

        case (op)
            OP_RTYPE, OP_FPU, OP_EXT: d_rd = instr[15:11];
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_LF: d_rd = rt_idx;
            default: d_rd = '0;
        endcase

        case (op)
            OP_ADDI:                 d_rt = imm_s;
            OP_ANDI, OP_ORI, OP_XORI: d_rt = {16'h0000, instr[15:0]};
            default:                 ;
        endcase

        case (op)
            OP_J, OP_JAL:             d_addr = {pc[31:28], instr[25:0], 2'b00};
            OP_BEQ, OP_BNE:           d_addr = {imm_s[29:0], 2'b00};
            OP_BC:                    d_addr = {{4{instr[25]}}, instr[25:0], 2'b00};
            OP_LW, OP_SW, OP_LF, OP_SF: d_addr = rs_int + imm_s;
            default:                  d_addr = '0;
        endcase
    end

    // Output register: load on enable, hold otherwise, single-cycle done
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done         <= 1'b0;
            exec_command <= '0;
            alu_command  <= '0;
            offset       <= '0;
            sh           <= '0;
            rs_no        <= '0;
            rt_no        <= '0;
            rd_out       <= '0;
            fmode1       <= 1'b0;
            fmode2       <= 1'b0;
            rs           <= '0;
            rt           <= '0;
            addr         <= '0;
            pc_out       <= '0;
        end else begin
            done <= enable;
            if (enable) begin
                exec_command <= op;
                alu_command  <= d_alu;
                offset       <= instr[15:0];
                sh           <= instr[10:6];
                rs_no        <= rs_idx;
                rt_no        <= rt_idx;
                rd_out       <= d_rd;
                fmode1       <= d_fm1;
                fmode2       <= d_fm2;
                rs           <= d_rs;
                rt           <= d_rt;
                addr         <= d_addr;
                pc_out       <= pc;
            end
        end
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode/operand-fetch stage sitting directly upstream of the exec stage.
- Accepts one instruction word plus its PC per enable pulse and splits it into exec_command/alu_command/offset/sh/register numbers.
- Reads operands from the integer and float register files it owns and builds rt-immediates and addresses; presents everything registered, with a one-cycle done pulse.
- Owns the writeback port: exec's wselector/rd_out/data write the register files here.

Parameters:
- RESET_PC_UNUSED, 0: none functional; block has no tunable parameters (the register file depth is fixed at 32+32).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  one-cycle pulse: instr/pc valid
- instr  in  32  instruction word
- pc  in  32  PC of instr
- done  out  1  one-cycle pulse: outputs valid
- exec_command  out  6  instr[31:26]
- alu_command  out  6  instr[5:0] for opcodes 000000, 010001 and 111111; 0 otherwise
- offset  out  16  instr[15:0]
- sh  out  5  instr[10:6]
- rs_no, rt_no  out  5 each  instr[25:21], instr[20:16]
- rd_out  out  5  destination (see Behaviour)
- fmode1, fmode2  out  1 each  rs/rt taken from float file
- rs, rt  out  32 each  operand values
- addr  out  32  jump target / branch displacement / memory address
- pc_out  out  32  registered copy of pc
- wb_sel  in  3  exec wselector: [1]=write, [0]=float file
- wb_rd  in  5  exec rd_out
- wb_data  in  32  exec data

Behaviour:
- Reset: done=0; all outputs=0; both 32x32 register files cleared to 0. Reset mid-operation discards a pending decode, and no done is issued.
- Latency: outputs are registered on the edge after enable; done=1 for exactly that one cycle. Outputs hold their values until the next enable. An enable every cycle is legal, giving throughput 1/cycle.
- Writeback:
  - When wb_sel[1]=1, write wb_data to float[wb_rd] if wb_sel[0]=1, else int[wb_rd].
  - int[0] is never written and always reads 0.
  - float[0] is writable.
- Write/read collision: if a write and enable occur in the same cycle and the read file/index match the write, the new wb_data is output (write-first bypass).
- rd_out:
  - instr[15:11] for opcodes 000000, 010001 and 111111.
  - instr[20:16] for 001000/001100/001101/001110/100011/110001.
  - 0 otherwise.
  - JAL rd is forced to 31 downstream, not here.
- fmode1=1 iff opcode=010001. fmode2=1 iff opcode=010001 or 111001 (SF data).
- rs = (fmode1 ? float : int)[rs_no].
- rt:
  - ADDI (001000): sign-extended offset.
  - ANDI/ORI/XORI (001100/001101/001110): zero-extended offset.
  - Else: (fmode2 ? float : int)[rt_no].
- addr:
  - J/JAL (000010/000011): {pc[31:28], instr[25:0], 2'b00}.
  - BEQ/BNE (000100/000101): sext(offset)<<2 (exec adds pc).
  - BC (110010): sext(instr[25:0])<<2, truncated to 32 bits.
  - LW/SW/LF/SF (100011/101011/110001/111001): int[rs_no] (after bypass) + sext(offset), modulo 2^32.
  - Else: 0.
- Unknown opcodes decode normally with addr=0; exec treats them as NOP.
- No internal forwarding from exec results beyond the same-cycle writeback bypass; exec resolves its own RAW hazards using rs_no/rt_no/fmode.

Test Plan:
- Reset, then an enable with ADDI $3,$2,-4 (instr=0x2043FFFC) when int[2]=10 → next cycle: done=1, exec_command=001000, rd_out=3, rs=10, rt=0xFFFFFFFC, fmode1=fmode2=0. The cycle after: done=0 and values hold.
- wb_sel=010, wb_rd=5, wb_data=0x1234 in the same cycle as an enable of R-type ADD reading rs_no=5 → rs=0x1234 (bypass). A write with wb_rd=0 followed by a read of int r0 → 0.
- Float file: wb_sel=011, wb_rd=0, data=0x3F800000, then FADD with rs_no=0 → fmode1=1, rs=0x3F800000. The same index read as an integer operand returns int[0]=0.
- LW with int[4]=0x100, offset=0xFFF8 → addr=0xF8, rd_out=rt_no. SF → fmode2=1, rt=float[rt_no].
- JAL with pc=0x40000010, instr[25:0]=0x0000040 → addr=0x40000100. BEQ with offset=0xFFFF → addr=0xFFFFFFFC.
- Back-to-back enables on 3 consecutive cycles → 3 done pulses with the matching decoded fields. Reset asserted the cycle after an enable → no done, outputs 0.
